// File: rtl/register_file_pkg.sv
// Shared CPU datapath constants: register geometry, write-enable encoding
// and the register reset value.
package register_file_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 1 << ADDR_W;

   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_REG  = 2'b01;
   localparam logic [1:0] RW_R0   = 2'b10;
   localparam logic [1:0] RW_BOTH = 2'b11;

   localparam logic [DATA_W-1:0] REG_RST = 16'h0000;
endpackage

// File: rtl/register_file.sv
// 16 x 16-bit register file: two combinational read ports, one general write
// port and a dedicated R0 write path for the secondary mul/div result.
module register_file
   import register_file_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] r0,
   input  logic [1:0]        reg_write,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic                            wr_reg_en;
   logic                            wr_r0_en;

   assign wr_reg_en = (reg_write == RW_REG) || (reg_write == RW_BOTH);
   assign wr_r0_en  = (reg_write == RW_R0)  || (reg_write == RW_BOTH);

   // R0 path is applied last so it wins when write_reg also targets R0.
   always_comb begin
      regs_d = regs_q;
      if (wr_reg_en) regs_d[write_reg] = write_data;
      if (wr_r0_en)  regs_d[0]         = r0;
   end

   always_ff @(posedge clk) begin
      if (reset) regs_q <= {NUM_REGS{REG_RST}};
      else       regs_q <= regs_d;
   end

   assign read_data1 = regs_q[read_reg1];
   assign read_data2 = regs_q[read_reg2];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset clear, write paths, R0 collision,
// no-bypass read timing and reset priority over writes.
module tb_register_file;
   import register_file_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] read_reg1, read_reg2, write_reg;
   logic [DATA_W-1:0] write_data, r0;
   logic [1:0]        reg_write;
   logic [DATA_W-1:0] read_data1, read_data2;

   int tests = 0;
   int fails = 0;

   register_file dut (
      .clk        (clk),
      .reset      (reset),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .r0         (r0),
      .reg_write  (reg_write),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int a = 0; a < 16; a++) begin
         read_reg1 = a[3:0];
         read_reg2 = 4'(15 - a);
         #1;
         tests++;
         if (read_data1 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_rd1 addr=%0d got=%h exp=0000", a, read_data1);
         end
         tests++;
         if (read_data2 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_rd2 addr=%0d got=%h exp=0000", 15 - a, read_data2);
         end
      end
   endtask

   task automatic test_normal_write();
      reg_write = 2'b01; write_reg = 4'd5; write_data = 16'hA5A5;
      tick();
      reg_write = 2'b00;
      read_reg1 = 4'd5; read_reg2 = 4'd5;
      #1;
      tests++;
      if (read_data1 !== 16'hA5A5) begin
         fails++; $display("FAIL normal_rd1 got=%h exp=a5a5", read_data1);
      end
      tests++;
      if (read_data2 !== 16'hA5A5) begin
         fails++; $display("FAIL normal_rd2 got=%h exp=a5a5", read_data2);
      end
      for (int a = 0; a < 16; a++) begin
         if (a == 5) continue;
         read_reg1 = a[3:0];
         #1;
         tests++;
         if (read_data1 !== 16'h0000) begin
            fails++; $display("FAIL normal_others addr=%0d got=%h exp=0000", a, read_data1);
         end
      end
   endtask

   task automatic test_no_write();
      reg_write = 2'b00; write_reg = 4'd5; write_data = 16'h1234; r0 = 16'h5678;
      tick();
      read_reg1 = 4'd5; read_reg2 = 4'd0;
      #1;
      tests++;
      if (read_data1 !== 16'hA5A5) begin
         fails++; $display("FAIL nowrite_r5 got=%h exp=a5a5", read_data1);
      end
      tests++;
      if (read_data2 !== 16'h0000) begin
         fails++; $display("FAIL nowrite_r0 got=%h exp=0000", read_data2);
      end
   endtask

   task automatic test_r0_path();
      reg_write = 2'b10; r0 = 16'h1234; write_reg = 4'd7; write_data = 16'hFFFF;
      tick();
      reg_write = 2'b00;
      read_reg1 = 4'd0; read_reg2 = 4'd7;
      #1;
      tests++;
      if (read_data1 !== 16'h1234) begin
         fails++; $display("FAIL r0path_r0 got=%h exp=1234", read_data1);
      end
      tests++;
      if (read_data2 !== 16'h0000) begin
         fails++; $display("FAIL r0path_r7 got=%h exp=0000", read_data2);
      end
   endtask

   task automatic test_dual_write();
      reg_write = 2'b11; write_reg = 4'd3; write_data = 16'hBEEF; r0 = 16'h0042;
      tick();
      reg_write = 2'b00;
      read_reg1 = 4'd3; read_reg2 = 4'd0;
      #1;
      tests++;
      if (read_data1 !== 16'hBEEF) begin
         fails++; $display("FAIL dual_r3 got=%h exp=beef", read_data1);
      end
      tests++;
      if (read_data2 !== 16'h0042) begin
         fails++; $display("FAIL dual_r0 got=%h exp=0042", read_data2);
      end
      // R0 as an ordinary destination through the normal port
      reg_write = 2'b01; write_reg = 4'd0; write_data = 16'h1111;
      tick();
      reg_write = 2'b00;
      #1;
      tests++;
      if (read_data2 !== 16'h1111) begin
         fails++; $display("FAIL r0_via_port got=%h exp=1111", read_data2);
      end
      reg_write = 2'b11; write_reg = 4'd0; write_data = 16'hDEAD; r0 = 16'h0042;
      tick();
      reg_write = 2'b00;
      #1;
      tests++;
      if (read_data2 !== 16'h0042) begin
         fails++; $display("FAIL collision_r0 got=%h exp=0042", read_data2);
      end
      read_reg1 = 4'd3;
      #1;
      tests++;
      if (read_data1 !== 16'hBEEF) begin
         fails++; $display("FAIL collision_r3 got=%h exp=beef", read_data1);
      end
   endtask

   task automatic test_bypass_and_reset();
      reg_write = 2'b01; write_reg = 4'd9; write_data = 16'h2222;
      tick();
      write_data = 16'h0F0F;
      read_reg1 = 4'd9;
      #1;
      tests++;
      if (read_data1 !== 16'h2222) begin
         fails++; $display("FAIL no_bypass got=%h exp=2222", read_data1);
      end
      tick();
      reg_write = 2'b00;
      tests++;
      if (read_data1 !== 16'h0F0F) begin
         fails++; $display("FAIL post_edge got=%h exp=0f0f", read_data1);
      end
      reset = 1'b1;
      reg_write = 2'b11; write_reg = 4'd4; write_data = 16'h5555; r0 = 16'h7777;
      tick();
      reset = 1'b0;
      reg_write = 2'b00;
      for (int a = 0; a < 16; a++) begin
         read_reg1 = a[3:0];
         read_reg2 = a[3:0];
         #1;
         tests++;
         if (read_data1 !== 16'h0000 || read_data2 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_prio addr=%0d got=%h/%h exp=0000", a, read_data1, read_data2);
         end
      end
      reg_write = 2'b01; write_reg = 4'd2; write_data = 16'hCAFE;
      tick();
      reg_write = 2'b00;
      read_reg1 = 4'd2;
      #1;
      tests++;
      if (read_data1 !== 16'hCAFE) begin
         fails++; $display("FAIL resume_write got=%h exp=cafe", read_data1);
      end
   endtask

   initial begin
      reset = 1'b0; reg_write = 2'b00;
      read_reg1 = '0; read_reg2 = '0; write_reg = '0;
      write_data = '0; r0 = '0;
      #2;
      test_reset();
      test_normal_write();
      test_no_write();
      test_r0_path();
      test_dual_write();
      test_bypass_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
